// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, mode encoding and state type for the demux_deser8 receiver.
package demux_pkg;
    localparam int WIDTH = 8;
    localparam int SEL_W = $clog2(WIDTH);
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SEQ = 1'b1;
    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
endpackage

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr: wrapping slot counter; clr and inc together restart at slot 1.
module demux_slot_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else cnt <= (clr ? '0 : cnt) + W'(inc);
    end
endmodule

// File: rtl/demux_deser8.sv
// demux_deser8: 1-to-8 serial demux receiver publishing a word when all slots are filled.
// Define DEMUX_DUP_ERR_EN to add the err duplicate-slot pulse output.
module demux_deser8
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic [SEL_W-1:0] s,
    input  logic             mode,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy
`ifdef DEMUX_DUP_ERR_EN
    ,
    output logic             err
`endif
);
    state_t           state;
    logic [WIDTH-1:0] mask, shadow, base_mask, dec, mask_nxt, shadow_nxt;
    logic [SEL_W-1:0] cnt, slot;
    logic             mode_q, abort, done;
    assign busy = state == COLLECT;
    // A mode flip while busy drops the partial frame; a bit on that cycle starts the new one.
    always_comb begin
        abort      = busy && (mode != mode_q);
        base_mask  = abort ? '0 : mask;
        slot       = (mode == MODE_SEQ) ? (abort ? '0 : cnt) : s;
        dec        = en ? (WIDTH'(1) << slot) : '0;
        mask_nxt   = base_mask | dec;
        shadow_nxt = (shadow & ~dec) | (din ? dec : '0);
        done       = en && (&mask_nxt);
    end
    demux_slot_ctr #(.W(SEL_W)) u_ctr (
        .clk(clk),
        .rst(rst),
        .clr(done || abort),
        .inc(en && (mode == MODE_SEQ) && !done),
        .cnt(cnt)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask    <= '0;
            shadow  <= '0;
            mode_q  <= MODE_ADDR;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= (!done && (|mask_nxt)) ? COLLECT : IDLE;
            mask    <= done ? '0 : mask_nxt;
            shadow  <= shadow_nxt;
            mode_q  <= mode;
            y       <= done ? shadow_nxt : y;
            y_valid <= done;
        end
    end
`ifdef DEMUX_DUP_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else err <= en && (mode == MODE_ADDR) && base_mask[s];
    end
`endif
endmodule
